// File: rtl/acc32_pkg.sv
// acc32_pkg: shared definitions for the acc32 accumulator stage.
//   state_e     FSM state encoding (IDLE, ACCUM, HOLD)
//   DATA_W_DEF  default data / accumulator width
//   CNT_W_DEF   default burst-length / sample-counter width
// Optional feature macro used by this slice: ACC32_SAT_EN (see acc32_stage).
package acc32_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage : acc32_pkg

// File: rtl/acc32_if.sv
// acc32_if: stream and control bundle of the acc32 accumulator stage.
//   start, len                 burst request (len sampled with start)
//   in_valid, in_ready, in_data  sample input stream
//   out_valid, out_ready, out_data, out_ovf  result stream
//   busy                       stage is inside a burst (ACCUM or HOLD)
// Modports: master = the side driving bursts and consuming results,
//           slave  = the accumulator stage itself.
//
// Handshake rule for both streams: a word moves on a rising clk edge where
// valid and ready are both 1. The producer keeps valid and data stable until
// that edge; ready may be asserted independently of valid.
interface acc32_if
  import acc32_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  logic              start;
  logic [CNT_W-1:0]  len;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_ovf;
  logic              busy;

  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, busy
  );

  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf, busy
  );

endinterface : acc32_if

// File: rtl/acc32_addc.sv
// acc32_addc: combinational unsigned adder with carry out.
//   a, b  in   DATA_W  operands
//   sum   out  DATA_W  low DATA_W bits of a + b
//   cout  out  1       carry out of bit DATA_W-1
module acc32_addc
  import acc32_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule : acc32_addc

// File: rtl/acc32_stage.sv
// acc32_stage: accumulates a burst of len input words into a running total
// and presents the total plus a sticky carry-overflow flag on a result port
// until it is taken.
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous reset, active-high
//   bus        slave modport of acc32_if (start/len, input stream,
//              result stream, busy)
//   dbg_state  out  state_e  current FSM state, for observation only
// Build option: ACC32_SAT_EN defined -> saturating unsigned accumulate
// (total pins at all ones once a carry occurs); undefined -> wrap-around.
// In both builds out_ovf records any carry during the burst.
module acc32_stage
  import acc32_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic   clk,
  input  logic   rst,
  acc32_if.slave bus,
  output state_e dbg_state
);

  state_e            state;
  state_e            state_nxt;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;
  logic [DATA_W-1:0] out_data_q;
  logic              out_ovf_q;

  logic              accept;
  logic              last;
  logic [DATA_W-1:0] add_sum;
  logic              add_cout;
  logic [DATA_W-1:0] acc_nxt;
  logic              ovf_nxt;

  acc32_addc #(.DATA_W(DATA_W)) u_addc (
    .a    (acc),
    .b    (bus.in_data),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign accept = (state == ACCUM) && bus.in_valid;
  // cnt holds the number of samples still owed; len=0 loads 0, which wraps
  // through 2**CNT_W-1 so a full 2**CNT_W samples are taken.
  assign last   = accept && (cnt == CNT_W'(1));

`ifdef ACC32_SAT_EN
  // Once a carry occurs acc is all ones; any further add either carries
  // again or adds zero, so it stays saturated for the rest of the burst.
  assign acc_nxt = add_cout ? {DATA_W{1'b1}} : add_sum;
`else
  assign acc_nxt = add_sum;
`endif
  assign ovf_nxt = ovf | add_cout;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start)     state_nxt = ACCUM;
      ACCUM:   if (last)          state_nxt = HOLD;
      HOLD:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && bus.start) begin
        acc <= '0;
        ovf <= 1'b0;
        cnt <= bus.len;
      end else if (accept) begin
        acc <= acc_nxt;
        ovf <= ovf_nxt;
        cnt <= cnt - CNT_W'(1);
        // The result registers are separate from acc so the presented
        // total survives the next burst's clear and accumulation.
        if (last) begin
          out_data_q <= acc_nxt;
          out_ovf_q  <= ovf_nxt;
        end
      end
    end
  end

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == HOLD);
  assign bus.busy      = (state == ACCUM) || (state == HOLD);
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;
  assign dbg_state     = state;

endmodule : acc32_stage

// File: tb/tb_acc32_stage.sv
// tb_acc32_stage: directed bench for acc32_stage with a result scoreboard.
// Expected {ovf, total} words are pushed when a burst's samples are driven
// and popped when the stage presents its result.
module tb_acc32_stage;
  import acc32_pkg::*;

  logic   clk    = 1'b0;
  logic   rst    = 1'b0;
  logic   clk_en = 1'b0;
  state_e dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];
  logic [32:0] model;

  // ---------------- clock / reset ----------------
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  acc32_if bus ();

  acc32_stage dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  function automatic logic [32:0] model_add(input logic [32:0] m, input logic [31:0] d);
    logic [32:0] s;
    s = {1'b0, m[31:0]} + {1'b0, d};
`ifdef ACC32_SAT_EN
    if (s[32]) s[31:0] = 32'hFFFF_FFFF;
`endif
    return {m[32] | s[32], s[31:0]};
  endfunction

  task automatic fail(input string tag, input logic [32:0] obs, input logic [32:0] expv);
    n_err++;
    $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    $error("%s miscompare", tag);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [7:0] l);
    bus.start = 1'b1;
    bus.len   = l;
    tick();
    bus.start = 1'b0;
    model = '0;
    n_vec++;
    if (dbg_state !== ACCUM) fail("start_accum", dbg_state, ACCUM);
  endtask

  task automatic send(input logic [31:0] d, input logic gap);
    logic rdy;
    rdy = 1'b0;
    if (gap) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 32'hDEAD_BEEF;
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
    end
    if (!rdy) begin
      n_vec++;
      if (rdy !== 1'b1) fail("accept_timeout", rdy, 1'b1);
    end
    model = model_add(model, d);
    bus.in_valid = 1'b0;
  endtask

  task automatic take_result(input string tag);
    logic [32:0] e;
    logic got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        got = 1'b1;
        break;
      end
    end
    n_vec++;
    if (got !== 1'b1) fail({tag, "_valid"}, got, 1'b1);
    if (got && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (bus.out_data !== e[31:0]) fail({tag, "_data"}, bus.out_data, e[31:0]);
      n_vec++;
      if (bus.out_ovf !== e[32]) fail({tag, "_ovf"}, bus.out_ovf, e[32]);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      n_vec++;
      if (bus.out_valid !== 1'b0) fail({tag, "_valid_drop"}, bus.out_valid, 1'b0);
      n_vec++;
      if (dbg_state !== IDLE) fail({tag, "_idle"}, dbg_state, IDLE);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [32:0] e;
    logic seen;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // 1. reset with the clock stopped, then start held during reset
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b0) fail("rst_in_ready", bus.in_ready, 1'b0);
    n_vec++;
    if (bus.out_valid !== 1'b0) fail("rst_out_valid", bus.out_valid, 1'b0);
    n_vec++;
    if (bus.out_data !== 32'h0) fail("rst_out_data", bus.out_data, 32'h0);
    n_vec++;
    if (bus.out_ovf !== 1'b0) fail("rst_out_ovf", bus.out_ovf, 1'b0);
    n_vec++;
    if (bus.busy !== 1'b0) fail("rst_busy", bus.busy, 1'b0);
    bus.start = 1'b1;
    bus.len   = 8'd4;
    clk_en    = 1'b1;
    repeat (3) tick();
    n_vec++;
    if (dbg_state !== IDLE) fail("rst_start_ignored", dbg_state, IDLE);
    bus.start = 1'b0;
    rst       = 1'b0;
    tick();

    // 2. len=4, 1..4 back-to-back, out_ready already high
    bus.out_ready = 1'b1;
    start_burst(8'd4);
    for (int i = 1; i <= 4; i++) send(32'(i), 1'b0);
    exp_q.push_back(model);
    n_vec++;
    if (bus.out_valid !== 1'b1) fail("b2_latency", bus.out_valid, 1'b1);
    take_result("b2");

    // 3. len=3, samples separated by idle cycles carrying junk data
    start_burst(8'd3);
    send(32'd5, 1'b1);
    send(32'd7, 1'b1);
    send(32'd9, 1'b1);
    exp_q.push_back(model);
    take_result("b3");

    // 4. carry out of bit 31
    start_burst(8'd2);
    send(32'hFFFF_FFFF, 1'b0);
    send(32'h0000_0002, 1'b0);
    exp_q.push_back(model);
    take_result("b4");

    // 5. result held with out_ready low while start / in_valid pulse
    start_burst(8'd2);
    send(32'h10, 1'b0);
    send(32'h20, 1'b0);
    exp_q.push_back(model);
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      bus.start    = i[0];
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h999;
      tick();
      n_vec++;
      if (bus.out_valid !== 1'b1) fail("hold_valid", bus.out_valid, 1'b1);
      n_vec++;
      if (bus.in_ready !== 1'b0) fail("hold_in_ready", bus.in_ready, 1'b0);
      n_vec++;
      if (bus.out_data !== e[31:0]) fail("hold_data", bus.out_data, e[31:0]);
      n_vec++;
      if (bus.out_ovf !== e[32]) fail("hold_ovf", bus.out_ovf, e[32]);
    end
    bus.in_valid  = 1'b0;
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    n_vec++;
    if (dbg_state !== IDLE) fail("hold_release_idle", dbg_state, IDLE);
    tick();
    n_vec++;
    if (dbg_state !== IDLE) fail("hold_start_ignored", dbg_state, IDLE);

    // 6a. len=0 -> 256 samples of 1
    start_burst(8'd0);
    for (int i = 0; i < 256; i++) send(32'd1, 1'b0);
    exp_q.push_back(model);
    take_result("b6");

    // 6b. reset after 2 of 4 samples aborts the burst
    start_burst(8'd4);
    send(32'd100, 1'b0);
    send(32'd200, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (dbg_state !== IDLE) fail("abort_state", dbg_state, IDLE);
    n_vec++;
    if (bus.busy !== 1'b0) fail("abort_busy", bus.busy, 1'b0);
    n_vec++;
    if (bus.out_data !== 32'h0) fail("abort_out_data", bus.out_data, 32'h0);
    #2 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) fail("abort_no_result", seen, 1'b0);
    start_burst(8'd2);
    send(32'd3, 1'b0);
    send(32'd4, 1'b0);
    exp_q.push_back(model);
    take_result("b7");

    n_vec++;
    if (exp_q.size() != 0) fail("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_acc32_stage
